// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: requester side plus the shared memory/MMU port.
// The arbiter connects through the master modport; requesters and memory use the slave modport.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256
);
  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS*DATA_W-1:0] req_data_i;
  logic [NUM_PORTS-1:0]        req_rd_i;
  logic [NUM_PORTS-1:0]        req_we_i;
  logic [DATA_W-1:0]           req_data_o;
  logic [31:0]                 req_page_ent_o;
  logic [NUM_PORTS-1:0]        req_ack_o;
  logic [NUM_PORTS-1:0]        req_fault_o;
  logic [NUM_PORTS-1:0]        req_err_o;
  logic [ADDR_W-1:0]           addr_o;
  logic [DATA_W-1:0]           data_o;
  logic                        rd_o;
  logic                        we_o;
  logic [DATA_W-1:0]           data_i;
  logic                        ack_i;
  logic                        hw_page_fault_i;
  logic [31:0]                 page_ent_i;
  logic [NUM_PORTS-1:0]        grant_o;
  logic                        busy_o;

  modport master (
    input  req_addr_i, req_data_i, req_rd_i, req_we_i,
    input  data_i, ack_i, hw_page_fault_i, page_ent_i,
    output req_data_o, req_page_ent_o, req_ack_o, req_fault_o, req_err_o,
    output addr_o, data_o, rd_o, we_o, grant_o, busy_o
  );

  modport slave (
    output req_addr_i, req_data_i, req_rd_i, req_we_i,
    output data_i, ack_i, hw_page_fault_i, page_ent_i,
    input  req_data_o, req_page_ent_o, req_ack_o, req_fault_o, req_err_o,
    input  addr_o, data_o, rd_o, we_o, grant_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter onto a single memory/MMU port: fixed-priority or round-robin
// selection, one transaction in flight, ack/fault routed to the owner, optional watchdog.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int RR_MODE   = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [DATA_W-1:0]    data_reg, data_next;
  logic                 rd_reg, rd_next;
  logic                 we_reg, we_next;
  logic [NUM_PORTS-1:0] grant_reg, grant_next;
  logic [NUM_PORTS-1:0] err_reg, err_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [PTR_W-1:0]     ptr_reg, ptr_next;

  logic [NUM_PORTS-1:0] req;
  logic [PTR_W-1:0]     win;
  logic                 done;

  function automatic logic [PTR_W-1:0] pick_fixed(input logic [NUM_PORTS-1:0] r);
    logic [PTR_W-1:0] w;
    w = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (r[i]) w = PTR_W'(i);
    end
    return w;
  endfunction

  // Scan offsets from farthest to nearest so the first hit after the pointer lands last.
  function automatic logic [PTR_W-1:0] pick_rr(input logic [NUM_PORTS-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] w;
    int idx;
    w = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx = int'(p) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (r[idx]) w = PTR_W'(idx);
    end
    return w;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign req[gi]             = bus.req_rd_i[gi] | bus.req_we_i[gi];
      assign bus.req_ack_o[gi]   = bus.ack_i & grant_reg[gi];
      assign bus.req_fault_o[gi] = bus.hw_page_fault_i & grant_reg[gi];
      assign bus.req_err_o[gi]   = err_reg[gi];
    end
  endgenerate

  assign win  = (RR_MODE != 0) ? pick_rr(req, ptr_reg) : pick_fixed(req);
  assign done = bus.ack_i | bus.hw_page_fault_i;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    rd_next    = rd_reg;
    we_next    = we_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    err_next   = '0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = BUSY;
          addr_next  = bus.req_addr_i[int'(win)*ADDR_W +: ADDR_W];
          data_next  = bus.req_we_i[win] ? bus.req_data_i[int'(win)*DATA_W +: DATA_W] : '0;
          rd_next    = bus.req_rd_i[win];
          we_next    = bus.req_we_i[win];
          grant_next = NUM_PORTS'(1) << win;
          cnt_next   = '0;
          ptr_next   = win;
        end
      end
      BUSY: begin
        if (done || (TIMEOUT > 0 && cnt_reg == CNT_LAST)) begin
          // A response in the final watchdog cycle still counts as a normal completion.
          state_next = IDLE;
          rd_next    = 1'b0;
          we_next    = 1'b0;
          grant_next = '0;
          cnt_next   = '0;
          if (!done) err_next = grant_reg;
        end else if (TIMEOUT > 0) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      rd_reg    <= 1'b0;
      we_reg    <= 1'b0;
      grant_reg <= '0;
      err_reg   <= '0;
      cnt_reg   <= '0;
      ptr_reg   <= PTR_W'(NUM_PORTS - 1);
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      rd_reg    <= rd_next;
      we_reg    <= we_next;
      grant_reg <= grant_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign bus.addr_o         = addr_reg;
  assign bus.data_o         = data_reg;
  assign bus.rd_o           = rd_reg;
  assign bus.we_o           = we_reg;
  assign bus.grant_o        = grant_reg;
  assign bus.busy_o         = (state_reg == BUSY);
  assign bus.req_data_o     = bus.data_i;
  assign bus.req_page_ent_o = bus.page_ent_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a fixed-priority arbiter with an 8-cycle watchdog and a round-robin
// arbiter with the watchdog disabled, both 4 ports, sharing clock and reset.
module tb_mem_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [NP-1:0] exp_grant [6];
    logic [NP-1:0] g_exp;

    mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bf ();
    mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) br ();

    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(8)) u_fix (
        .clk(clk), .rst(rst), .bus(bf)
    );
    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(0)) u_rr (
        .clk(clk), .rst(rst), .bus(br)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bf.req_addr_i = '0; bf.req_data_i = '0; bf.req_rd_i = '0; bf.req_we_i = '0;
        bf.data_i = '0; bf.ack_i = 1'b0; bf.hw_page_fault_i = 1'b0; bf.page_ent_i = '0;
        br.req_addr_i = '0; br.req_data_i = '0; br.req_rd_i = '0; br.req_we_i = '0;
        br.data_i = '0; br.ack_i = 1'b0; br.hw_page_fault_i = 1'b0; br.page_ent_i = '0;

        // Reset and idle
        repeat (3) step();
        chk("rst_busy", bf.busy_o, 1'b0);
        chk("rst_grant", bf.grant_o, 4'b0000);
        rst = 1'b1;
        repeat (10) step();
        chk("idle_rd", bf.rd_o, 1'b0);
        chk("idle_we", bf.we_o, 1'b0);
        chk("idle_addr", bf.addr_o, 32'h0);
        chk("idle_data", bf.data_o, 64'h0);
        chk("idle_rr_busy", br.busy_o, 1'b0);
        bf.ack_i = 1'b1; bf.hw_page_fault_i = 1'b1; br.ack_i = 1'b1;
        bf.page_ent_i = 32'hA5A5_0F0F;
        #1;
        chk("idle_ack", bf.req_ack_o, 4'b0000);
        chk("idle_fault", bf.req_fault_o, 4'b0000);
        chk("idle_rr_ack", br.req_ack_o, 4'b0000);
        chk("page_ent", bf.req_page_ent_o, 32'hA5A5_0F0F);
        step();
        chk("idle_ack_busy", bf.busy_o, 1'b0);
        bf.ack_i = 1'b0; bf.hw_page_fault_i = 1'b0; br.ack_i = 1'b0;

        // Single read on port 1; write data present but must not reach data_o
        bf.req_addr_i[1*AW +: AW] = 32'h0000_1040;
        bf.req_data_i[1*DW +: DW] = 64'h5555_5555_5555_5555;
        bf.req_rd_i = 4'b0010;
        step();
        chk("rd_rise", bf.rd_o, 1'b1);
        chk("rd_addr", bf.addr_o, 32'h0000_1040);
        chk("rd_grant", bf.grant_o, 4'b0010);
        chk("rd_data_zero", bf.data_o, 64'h0);
        chk("rd_we", bf.we_o, 1'b0);
        repeat (3) step();
        chk("rd_wait_busy", bf.busy_o, 1'b1);
        bf.ack_i = 1'b1; bf.data_i = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("rd_ack", bf.req_ack_o, 4'b0010);
        chk("rd_rdata", bf.req_data_o, 64'hDEAD_BEEF_0123_4567);
        chk("rd_nofault", bf.req_fault_o, 4'b0000);
        step();
        $display("txn single_read port=1 addr=%0h", 32'h0000_1040);
        bf.ack_i = 1'b0; bf.req_rd_i = 4'b0000;
        chk("rd_done_rd", bf.rd_o, 1'b0);
        chk("rd_done_busy", bf.busy_o, 1'b0);
        chk("rd_done_grant", bf.grant_o, 4'b0000);

        // Fixed priority: ports 0 and 2 request continuously, port 0 always wins
        bf.req_addr_i[0*AW +: AW] = 32'h0000_0100;
        bf.req_addr_i[2*AW +: AW] = 32'h0000_0200;
        bf.req_rd_i = 4'b0101;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("fix_grant", bf.grant_o, 4'b0001);
            chk("fix_addr", bf.addr_o, 32'h0000_0100);
            bf.ack_i = 1'b1;
            step();
            $display("txn fixed t=%0d grant=%b", t, 4'b0001);
            bf.ack_i = 1'b0;
            chk("fix_idle", bf.busy_o, 1'b0);
        end
        bf.req_rd_i = 4'b0000;

        // Watchdog abort on port 3
        bf.req_addr_i[3*AW +: AW] = 32'h0000_3000;
        bf.req_rd_i = 4'b1000;
        step();
        chk("wd_rise", bf.rd_o, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("wd_hold_busy", bf.busy_o, 1'b1);
            chk("wd_hold_err", bf.req_err_o, 4'b0000);
        end
        step();
        $display("txn watchdog_abort port=3");
        bf.req_rd_i = 4'b0000;
        chk("wd_err", bf.req_err_o, 4'b1000);
        chk("wd_busy", bf.busy_o, 1'b0);
        chk("wd_rd", bf.rd_o, 1'b0);
        chk("wd_grant", bf.grant_o, 4'b0000);
        step();
        chk("wd_err_pulse", bf.req_err_o, 4'b0000);

        // Watchdog race: ack in the 8th cycle completes normally
        bf.req_rd_i = 4'b1000;
        step();
        for (int i = 0; i < 7; i++) step();
        chk("wdr_busy", bf.busy_o, 1'b1);
        bf.ack_i = 1'b1;
        #1;
        chk("wdr_ack", bf.req_ack_o, 4'b1000);
        step();
        $display("txn watchdog_race port=3");
        bf.ack_i = 1'b0; bf.req_rd_i = 4'b0000;
        chk("wdr_noerr", bf.req_err_o, 4'b0000);
        chk("wdr_busy_clr", bf.busy_o, 1'b0);
        step();
        chk("wdr_noerr2", bf.req_err_o, 4'b0000);

        // Page fault on port 0 write
        bf.req_addr_i[0*AW +: AW] = 32'hDEAD_0000;
        bf.req_data_i[0*DW +: DW] = 64'h1234_5678_9ABC_DEF0;
        bf.req_we_i = 4'b0001;
        step();
        chk("pf_we", bf.we_o, 1'b1);
        chk("pf_rd", bf.rd_o, 1'b0);
        chk("pf_addr", bf.addr_o, 32'hDEAD_0000);
        chk("pf_data", bf.data_o, 64'h1234_5678_9ABC_DEF0);
        bf.hw_page_fault_i = 1'b1;
        #1;
        chk("pf_fault", bf.req_fault_o, 4'b0001);
        chk("pf_noack", bf.req_ack_o, 4'b0000);
        step();
        $display("txn page_fault port=0 addr=%0h", 32'hDEAD_0000);
        bf.hw_page_fault_i = 1'b0; bf.req_we_i = 4'b0000;
        chk("pf_idle", bf.busy_o, 1'b0);
        chk("pf_we_clr", bf.we_o, 1'b0);

        // Round-robin: ports 0,1 read, port 3 writes
        br.req_data_i[3*DW +: DW] = 64'hCAFE_F00D_0000_0003;
        br.req_addr_i[3*AW +: AW] = 32'h0000_0333;
        br.req_rd_i = 4'b0011;
        br.req_we_i = 4'b1000;
        exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b1000;
        exp_grant[3] = 4'b0001; exp_grant[4] = 4'b0010; exp_grant[5] = 4'b1000;
        for (int t = 0; t < 6; t++) begin
            g_exp = exp_grant[t];
            step();
            chk("rr_grant", br.grant_o, g_exp);
            if (g_exp == 4'b1000) begin
                chk("rr_we", br.we_o, 1'b1);
                chk("rr_wdata", br.data_o, 64'hCAFE_F00D_0000_0003);
            end
            br.ack_i = 1'b1;
            step();
            $display("txn rr t=%0d grant=%b", t, g_exp);
            br.ack_i = 1'b0;
        end
        br.req_rd_i = 4'b0000; br.req_we_i = 4'b0000;

        // rd and we together are both forwarded; TIMEOUT=0 never aborts
        br.req_data_i[1*DW +: DW] = 64'h77;
        br.req_rd_i = 4'b0010; br.req_we_i = 4'b0010;
        step();
        chk("rw_rd", br.rd_o, 1'b1);
        chk("rw_we", br.we_o, 1'b1);
        chk("rw_data", br.data_o, 64'h77);
        repeat (20) step();
        chk("nowd_busy", br.busy_o, 1'b1);
        chk("nowd_err", br.req_err_o, 4'b0000);
        br.ack_i = 1'b1;
        step();
        $display("txn rw_no_watchdog port=1");
        br.ack_i = 1'b0; br.req_rd_i = 4'b0000; br.req_we_i = 4'b0000;
        chk("nowd_done", br.busy_o, 1'b0);

        // Asynchronous reset mid-transaction
        bf.req_rd_i = 4'b0100;
        step();
        chk("ar_busy", bf.busy_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("ar_rd", bf.rd_o, 1'b0);
        chk("ar_grant", bf.grant_o, 4'b0000);
        bf.ack_i = 1'b1;
        #1;
        chk("ar_noack", bf.req_ack_o, 4'b0000);
        $display("txn async_reset port=2");
        bf.ack_i = 1'b0; bf.req_rd_i = 4'b0000;
        step();
        rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
